// File: rtl/valrdy_pkg.sv
// Shared constants and width helpers for the valrdyqueue library.
package valrdy_pkg;

  localparam int DEFAULT_BITWIDTH = 32;
  localparam int DEFAULT_ENTRIES  = 4;

  // Bits needed to index one of `entries` storage slots.
  function automatic int ptr_width(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

  // Bits needed to hold an occupancy of 0..entries inclusive.
  function automatic int count_width(input int entries);
    return $clog2(entries) + 1;
  endfunction

endpackage

// File: rtl/valrdy_fifo_ff.sv
// Enable register with synchronous active-high reset; the building block
// for queue storage, pointers and occupancy.
module ff #(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  // Clear on reset, otherwise load D when enabled.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      Q <= '0;
    end else if (EN) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/valrdy_fifo.sv
// General-purpose val/rdy decoupling queue. Storage, pointers and
// occupancy are enable registers; this module supplies the write/read
// selects, the occupancy arithmetic and the full/empty decode.
// No bypass and no full pass-through: both handshake outputs are decoded
// from registered state only.
module valrdy_fifo
  import valrdy_pkg::*;
#(
  parameter int BITWIDTH = DEFAULT_BITWIDTH,
  parameter int ENTRIES  = DEFAULT_ENTRIES
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic [BITWIDTH-1:0]              RECV_MSG,
  input  logic                             RECV_VAL,
  output logic                             RECV_RDY,
  output logic [BITWIDTH-1:0]              SEND_MSG,
  output logic                             SEND_VAL,
  input  logic                             SEND_RDY,
  output logic [count_width(ENTRIES)-1:0]  COUNT
);

  localparam int PW = ptr_width(ENTRIES);
  localparam int CW = count_width(ENTRIES);

  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic [PW-1:0]       w_wr_ptr_nxt;
  logic [PW-1:0]       w_rd_ptr_nxt;
  logic [CW-1:0]       w_count_nxt;
  logic                w_count_en;
  logic                w_recv_rdy;
  logic                w_send_val;
  logic                w_enq;
  logic                w_deq;
  logic [ENTRIES-1:0]  w_entry_en;
  logic [BITWIDTH-1:0] r_entries [ENTRIES];

  // Handshake decode from registered occupancy; reset forces both low.
  always_comb begin
    w_recv_rdy = !RESET && (r_count != CW'(ENTRIES));
    w_send_val = !RESET && (r_count != '0);
    w_enq      = RECV_VAL && w_recv_rdy;
    w_deq      = SEND_RDY && w_send_val;
  end

  // Pointer increments wrap by natural overflow (ENTRIES is a power of two).
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr + PW'(1);
    w_rd_ptr_nxt = r_rd_ptr + PW'(1);
  end

  // Occupancy only moves when exactly one side fires.
  always_comb begin
    w_count_en  = w_enq ^ w_deq;
    w_count_nxt = w_enq ? (r_count + CW'(1)) : (r_count - CW'(1));
  end

  ff #(.WIDTH(PW)) u_wr_ptr (
    .CLK   (CLK),
    .RESET (RESET),
    .EN    (w_enq),
    .D     (w_wr_ptr_nxt),
    .Q     (r_wr_ptr)
  );

  ff #(.WIDTH(PW)) u_rd_ptr (
    .CLK   (CLK),
    .RESET (RESET),
    .EN    (w_deq),
    .D     (w_rd_ptr_nxt),
    .Q     (r_rd_ptr)
  );

  ff #(.WIDTH(CW)) u_count (
    .CLK   (CLK),
    .RESET (RESET),
    .EN    (w_count_en),
    .D     (w_count_nxt),
    .Q     (r_count)
  );

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    assign w_entry_en[gi] = w_enq && (r_wr_ptr == PW'(gi));

    ff #(.WIDTH(BITWIDTH)) u_entry (
      .CLK   (CLK),
      .RESET (RESET),
      .EN    (w_entry_en[gi]),
      .D     (RECV_MSG),
      .Q     (r_entries[gi])
    );
  end

  // Head-of-queue read mux straight off the storage registers.
  always_comb begin
    SEND_MSG = r_entries[r_rd_ptr];
  end

  // Drive outputs from the decoded/registered state.
  always_comb begin
    RECV_RDY = w_recv_rdy;
    SEND_VAL = w_send_val;
    COUNT    = r_count;
  end

endmodule

// File: tb/tb_valrdy_fifo.sv
// Directed bench for valrdy_fifo: a reference occupancy model pushes every
// accepted message into a scoreboard; a negedge monitor pops and compares
// whenever the DUT presents a message that the consumer takes.
module tb_valrdy_fifo;

  localparam int BW = 32;
  localparam int N  = 4;
  localparam int CW = 3;

  logic          CLK      = 1'b0;
  logic          RESET    = 1'b1;
  logic [BW-1:0] RECV_MSG = '0;
  logic          RECV_VAL = 1'b0;
  logic          SEND_RDY = 1'b0;
  logic          RECV_RDY;
  logic          SEND_VAL;
  logic [BW-1:0] SEND_MSG;
  logic [CW-1:0] COUNT;

  int            n_chk   = 0;
  int            n_fail  = 0;
  int            n_pop   = 0;
  int            m_count = 0;
  bit            chk_en  = 1'b0;
  bit            m_enq;
  bit            m_deq;
  logic [BW-1:0] exp_q [$];
  int            p0;

  valrdy_fifo #(.BITWIDTH(BW), .ENTRIES(N)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .RECV_MSG (RECV_MSG),
    .RECV_VAL (RECV_VAL),
    .RECV_RDY (RECV_RDY),
    .SEND_MSG (SEND_MSG),
    .SEND_VAL (SEND_VAL),
    .SEND_RDY (SEND_RDY),
    .COUNT    (COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference occupancy model and scoreboard producer.
  always @(posedge CLK) begin
    if (RESET) begin
      m_count <= 0;
      exp_q.delete();
    end else begin
      m_enq = RECV_VAL && (m_count != N);
      m_deq = SEND_RDY && (m_count != 0);
      if (m_enq) exp_q.push_back(RECV_MSG);
      m_count <= m_count + int'(m_enq) - int'(m_deq);
    end
  end

  // Monitor: status against the model, data against the scoreboard.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("count", 64'(COUNT), 64'(m_count));
      check("recv_rdy", 64'(RECV_RDY), 64'(!RESET && (m_count != N)));
      check("send_val", 64'(SEND_VAL), 64'(!RESET && (m_count != 0)));
      if (SEND_VAL === 1'b1 && SEND_RDY) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL send_unexpected: got %0h expected no message", SEND_MSG);
        end else begin
          check("send_msg", 64'(SEND_MSG), 64'(exp_q.pop_front()));
          n_pop++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset, then idle.
    RESET = 1'b1;
    tick();
    tick();
    chk_en = 1'b1;
    RESET  = 1'b0;
    @(negedge CLK);
    check("rst_count", 64'(COUNT), 64'd0);
    check("rst_recv_rdy", 64'(RECV_RDY), 64'd1);
    check("rst_send_val", 64'(SEND_VAL), 64'd0);
    check("rst_send_msg", 64'(SEND_MSG), 64'd0);

    // Fill to full, offer a fifth message that must be refused.
    SEND_RDY = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      RECV_VAL = 1'b1;
      RECV_MSG = 32'hA + 32'(i);
      tick();
    end
    RECV_MSG = 32'hE;
    @(negedge CLK);
    check("full_count", 64'(COUNT), 64'd4);
    check("full_recv_rdy", 64'(RECV_RDY), 64'd0);
    tick();
    RECV_VAL = 1'b0;
    SEND_RDY = 1'b1;
    p0 = n_pop;
    repeat (4) tick();
    @(negedge CLK);
    check("drain_count", 64'(COUNT), 64'd0);
    check("drain_pops", 64'(n_pop - p0), 64'd4);

    // Streaming, both sides always ready.
    tick();
    p0 = n_pop;
    for (int i = 1; i <= 20; i++) begin
      RECV_VAL = 1'b1;
      RECV_MSG = 32'(i);
      tick();
      if (i >= 2) begin
        @(negedge CLK);
        check("stream_count", 64'(COUNT), 64'd1);
      end
    end
    RECV_VAL = 1'b0;
    tick();
    @(negedge CLK);
    check("stream_pops", 64'(n_pop - p0), 64'd20);
    check("stream_count_end", 64'(COUNT), 64'd0);

    // Full with consumer ready: dequeue only, then enqueue+dequeue.
    tick();
    SEND_RDY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      RECV_VAL = 1'b1;
      RECV_MSG = 32'h10 + 32'(i);
      tick();
    end
    RECV_MSG = 32'h14;
    SEND_RDY = 1'b1;
    @(negedge CLK);
    check("fulldeq_recv_rdy", 64'(RECV_RDY), 64'd0);
    tick();
    @(negedge CLK);
    check("deq_only_count", 64'(COUNT), 64'd3);
    check("deq_only_recv_rdy", 64'(RECV_RDY), 64'd1);
    tick();
    RECV_VAL = 1'b0;
    @(negedge CLK);
    check("both_fire_count", 64'(COUNT), 64'd3);
    repeat (3) tick();
    @(negedge CLK);
    check("fulldeq_drained", 64'(COUNT), 64'd0);

    // Latency: no bypass into an empty queue.
    tick();
    SEND_RDY = 1'b0;
    RECV_VAL = 1'b1;
    RECV_MSG = 32'h55;
    @(negedge CLK);
    check("nobypass_send_val", 64'(SEND_VAL), 64'd0);
    tick();
    RECV_VAL = 1'b0;
    @(negedge CLK);
    check("lat_send_val", 64'(SEND_VAL), 64'd1);
    check("lat_send_msg", 64'(SEND_MSG), 64'h55);
    tick();
    SEND_RDY = 1'b1;
    tick();
    @(negedge CLK);
    check("lat_drained", 64'(COUNT), 64'd0);

    // Mid-operation reset discards queued data.
    tick();
    SEND_RDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      RECV_VAL = 1'b1;
      RECV_MSG = 32'h21 + 32'(i);
      tick();
    end
    RECV_VAL = 1'b0;
    RESET    = 1'b1;
    @(negedge CLK);
    check("prerst_count", 64'(COUNT), 64'd3);
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    check("midrst_count", 64'(COUNT), 64'd0);
    check("midrst_send_val", 64'(SEND_VAL), 64'd0);
    check("midrst_recv_rdy", 64'(RECV_RDY), 64'd1);
    check("midrst_send_msg", 64'(SEND_MSG), 64'd0);
    tick();
    RECV_VAL = 1'b1;
    RECV_MSG = 32'h77;
    tick();
    RECV_VAL = 1'b0;
    SEND_RDY = 1'b1;
    p0 = n_pop;
    @(negedge CLK);
    check("post_rst_head", 64'(SEND_MSG), 64'h77);
    tick();
    @(negedge CLK);
    check("post_rst_pops", 64'(n_pop - p0), 64'd1);
    check("post_rst_count", 64'(COUNT), 64'd0);

    tick();
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
